muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide execute unit implementing the RV32M operations, sitting beside the single-cycle ALU in the execute stage.
- Operands come from register-file read data 1 and 2; the result feeds the register write-back mux.
- Uses a start/busy/done handshake so the core can stall the PC while an operation is in flight.
- Generalises the ALU to any operand width XLEN, with multi-cycle sequential arithmetic and defined divide corner cases.

Parameters:
- XLEN, 32, operand and result width in bits (>= 8, even).
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- funct3  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  XLEN  operand rs1.
- b  input  XLEN  operand rs2.
- busy  output  1  operation in progress; start ignored.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  result; held until the next accepted start.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, busy=0, done=0, result=0, counter=0, internal registers 0. Reset mid-operation discards the operation; no done pulse is produced.
- States: IDLE, MUL, DIV, FIN.
- Accept rule: start=1 while busy=0 (IDLE or FIN) latches funct3, a, b and the sign flags.
- Transitions:
  - IDLE/FIN + start, funct3[2]=0 -> MUL.
  - IDLE/FIN + start, funct3[2]=1, special case -> FIN directly.
  - IDLE/FIN + start, funct3[2]=1, otherwise -> DIV.
  - IDLE/FIN with no start -> IDLE.
  - MUL/DIV -> FIN when the counter reaches XLEN.
- busy=1 exactly in MUL and DIV. done=1 exactly in FIN. start during busy is ignored, and latched operands are unaffected.
- Back-to-back: start asserted while done=1 is accepted. The new operation begins, and result keeps the old value until its own FIN.
- Sign handling:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - Others: unsigned.
  - Magnitudes are taken at accept. The result sign is fixed at the transition into FIN: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
- MUL state:
  - Shift-add over a 2*XLEN accumulator, one multiplier bit per cycle, XLEN cycles.
  - MUL returns the low XLEN bits of the signed-corrected product. MULH, MULHSU and MULHU return the high XLEN bits.
- DIV state:
  - Restoring division, one quotient bit per cycle, XLEN cycles.
  - Remainder register is XLEN+1 bits wide to hold the trial-subtract sign.
- Special cases (1-cycle path, no iteration):
  - b=0: DIV/DIVU give all ones; REM/REMU give a.
  - Signed overflow (a = most negative value, b = all ones, DIV/REM): DIV gives a; REM gives 0.
- Latency, with the start edge as E0:
  - Normal path: done is high in the cycle after edge E(XLEN+1).
  - Special-case path: done is high after edge E1.
  - For XLEN=32: 33 cycles normal, 1 cycle special.
- result is registered and updated only on entry to FIN.
- funct3 and operand inputs may change freely after the accept cycle.

Decomposition:
- Shared definitions file, alongside the existing ALU/opcode macros:
  - the eight M-extension funct3 codes;
  - the funct7 value 0000001;
  - the state enum typedef (IDLE/MUL/DIV/FIN).
- Single module; no sub-module is required.
- Optional sub-module muldiv_sign_fix (combinational two's-complement magnitude/negate helper), instantiated for operand conditioning and result correction.

Test Plan:
- Reset during MUL: assert reset at cycle 10 -> busy=0, done=0, result=0 immediately. After release, no done pulse appears.
- MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 33 cycles after start, busy high for cycles 1..32. Then MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14; REMU -> 2.
- Corner cases with done after 1 cycle:
  - DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Handshake:
  - start held high continuously while busy -> only one operation is accepted; a and b changes are ignored.
  - start asserted in the done cycle -> the second operation completes 33 cycles later; result holds the first value in between.
  - XLEN=16 instance: MULHU 0xFFFF×0xFFFF -> 0xFFFE, done after 17 cycles.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared RV32M definitions for the multiply/divide execute unit:
// funct3 operation codes, the M-extension funct7 and the sequencer states.
package muldiv_unit_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } md_state_e;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic op_signed_a(input logic [2:0] f);
    return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM.
  function automatic logic op_signed_b(input logic [2:0] f);
    return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Start/busy/done handshake between the execute stage and the mul/div unit.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, a, b, input busy, done, result);
  modport slave  (input start, funct3, a, b, output busy, done, result);
endinterface

// File: rtl/muldiv_sign_fix.sv
// Two's-complement conditional negate: magnitude of a signed operand on the
// way in, sign correction of a product/quotient/remainder on the way out.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);
  assign res = neg ? (~val + W'(1)) : val;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide, one bit per cycle, with single-cycle divide-by-zero and overflow.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op;
  logic              sa;
  logic              sb;
  logic [2*XLEN-1:0] acc;   // MUL: {partial high, multiplier}; DIV: low half dividend -> quotient
  logic [XLEN:0]     rem;   // partial remainder with the next dividend bit appended
  logic [XLEN-1:0]   opnd;  // multiplicand or divisor magnitude

  logic              in_sa;
  logic              in_sb;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              in_special;
  logic [XLEN-1:0]   special_res;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc_n;
  logic [XLEN:0]     trial;
  logic [XLEN-1:0]   r_new;
  logic [XLEN-1:0]   quo_n;
  logic              last_iter;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN-1:0]   div_res;

  assign in_sa = op_signed_a(bus.funct3) & bus.a[XLEN-1];
  assign in_sb = op_signed_b(bus.funct3) & bus.b[XLEN-1];

  muldiv_sign_fix #(.W(XLEN)) u_a_mag (.val(bus.a), .neg(in_sa), .res(a_mag));
  muldiv_sign_fix #(.W(XLEN)) u_b_mag (.val(bus.b), .neg(in_sb), .res(b_mag));

  // Divide corner cases that bypass iteration: x/0 and MOST_NEG/-1.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    special_res = '0;
    in_special  = bus.funct3[2] &
                  ((bus.b == '0) | (~bus.funct3[0] & (bus.a == MOST_NEG) & (bus.b == '1)));
    if (bus.b == '0) special_res = bus.funct3[1] ? bus.a : '1;
    else             special_res = bus.funct3[1] ? '0 : bus.a;
  end

  // One multiply step and one restoring-divide step, selected by state.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_acc_n = {mul_sum, acc[XLEN-1:1]};
    trial     = rem - {1'b0, opnd};
    r_new     = trial[XLEN] ? rem[XLEN-1:0] : trial[XLEN-1:0];
    quo_n     = {acc[XLEN-2:0], ~trial[XLEN]};
    last_iter = (cnt == CNT_W'(XLEN - 1));
  end

  muldiv_sign_fix #(.W(2*XLEN)) u_prod (.val(mul_acc_n), .neg(sa ^ sb), .res(prod_fix));
  muldiv_sign_fix #(.W(XLEN))   u_quo  (.val(quo_n),     .neg(sa ^ sb), .res(quo_fix));
  muldiv_sign_fix #(.W(XLEN))   u_rem  (.val(r_new),     .neg(sa),      .res(rem_fix));

  assign mul_res = (op == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  assign div_res = op[1] ? rem_fix : quo_fix;

  // Sequencer: accept, iterate, and register busy/done/result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      op         <= '0;
      sa         <= 1'b0;
      sb         <= 1'b0;
      acc        <= '0;
      rem        <= '0;
      opnd       <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every read sees the pre-edge value.
      bus.done <= 1'b0;
      unique case (state)
        IDLE, FIN: begin
          state <= IDLE;
          if (bus.start) begin
            op  <= bus.funct3;
            sa  <= in_sa;
            sb  <= in_sb;
            cnt <= '0;
            if (!bus.funct3[2]) begin
              state    <= MUL;
              bus.busy <= 1'b1;
              acc      <= {{XLEN{1'b0}}, b_mag};
              opnd     <= a_mag;
            end else if (in_special) begin
              state      <= FIN;
              bus.done   <= 1'b1;
              bus.result <= special_res;
            end else begin
              state    <= DIV;
              bus.busy <= 1'b1;
              acc      <= {{XLEN{1'b0}}, a_mag[XLEN-2:0], 1'b0};
              rem      <= {{XLEN{1'b0}}, a_mag[XLEN-1]};
              opnd     <= b_mag;
            end
          end
        end
        MUL: begin
          acc <= mul_acc_n;
          cnt <= cnt + CNT_W'(1);
          if (last_iter) begin
            state      <= FIN;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            bus.result <= mul_res;
          end
        end
        DIV: begin
          acc <= {acc[2*XLEN-1:XLEN], quo_n};
          rem <= {r_new, acc[XLEN-1]};
          cnt <= cnt + CNT_W'(1);
          if (last_iter) begin
            state      <= FIN;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            bus.result <= div_res;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: an arithmetic reference model with a
// per-cycle compare process, plus hand-computed directed vectors.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(32)) bus ();
  muldiv_unit_if #(.XLEN(16)) bus16 ();

  muldiv_unit #(.XLEN(32)) dut   (.clk(clk), .reset(reset), .bus(bus));
  muldiv_unit #(.XLEN(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected RV32M result from plain 64-bit arithmetic.
  function automatic logic [31:0] model_res(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    longint          p;
    longint unsigned pu;
    case (f)
      F3_MUL:    begin pu = ua * ub;           return pu[31:0];  end
      F3_MULH:   begin p  = sa * sb;           return p[63:32];  end
      F3_MULHSU: begin p  = sa * longint'(ub); return p[63:32];  end
      F3_MULHU:  begin pu = ua * ub;           return pu[63:32]; end
      F3_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      F3_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        pu = ua / ub; return pu[31:0];
      end
      F3_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        pu = ua % ub; return pu[31:0];
      end
    endcase
  endfunction

  function automatic logic model_special(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    return f[2] && (b == 0 || ((f == F3_DIV || f == F3_REM) &&
                               a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Reference timing: an op in flight counts down XLEN cycles to its done cycle.
  int          m_remain;
  logic        m_done;
  logic [31:0] m_result;
  logic [31:0] m_pend;

  // Model state advances on the same edges as the DUT.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_remain <= 0;
      m_done   <= 1'b0;
      m_result <= '0;
      m_pend   <= '0;
    end else if (m_remain > 0) begin
      m_remain <= m_remain - 1;
      m_done   <= (m_remain == 1);
      if (m_remain == 1) m_result <= m_pend;
    end else begin
      m_done <= 1'b0;
      if (bus.start) begin
        m_pend <= model_res(bus.funct3, bus.a, bus.b);
        if (model_special(bus.funct3, bus.a, bus.b)) begin
          m_done   <= 1'b1;
          m_result <= model_res(bus.funct3, bus.a, bus.b);
        end else begin
          m_remain <= XLEN;
        end
      end
    end
  end

  // Compare the 32-bit unit against the model on every falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("busy",   bus.busy,   (m_remain > 0));
      check("done",   bus.done,   m_done);
      check("result", bus.result, m_result);
    end
  end

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lit, input int lat);
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.funct3 = ~f; bus.a = ~a; bus.b = ~b;
    n = 1;
    while (!bus.done && n < 64) begin
      @(negedge clk);
      n++;
    end
    check({name, "_lat"}, n, lat);
    check(name, bus.result, lit);
  endtask

  task automatic run16(input string name, input logic [2:0] f, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] lit, input int lat);
    int n;
    @(negedge clk);
    bus16.start = 1'b1; bus16.funct3 = f; bus16.a = a; bus16.b = b;
    @(negedge clk);
    bus16.start = 1'b0; bus16.a = ~a; bus16.b = ~b;
    n = 1;
    while (!bus16.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_lat"}, n, lat);
    check(name, bus16.result, lit);
  endtask

  initial begin
    int   n;
    logic seen;
    reset = 1'b1;
    bus.start = 1'b0;   bus.funct3 = '0;   bus.a = '0;   bus.b = '0;
    bus16.start = 1'b0; bus16.funct3 = '0; bus16.a = '0; bus16.b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",   bus.busy,   1'b0);
    check("rst_done",   bus.done,   1'b0);
    check("rst_result", bus.result, 32'h0);
    reset = 1'b0;

    // Multiply family
    run_op("mul",    F3_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mulhu",  F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulh",   F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);

    // Divide family
    run_op("div",  F3_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem",  F3_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("divu", F3_DIVU, 32'd100,       32'd7, 32'd14,        33);
    run_op("remu", F3_REMU, 32'd100,       32'd7, 32'd2,         33);

    // Single-cycle corner cases
    run_op("divu0", F3_DIVU, 32'd100,       32'd0,         32'hFFFF_FFFF, 1);
    run_op("remu0", F3_REMU, 32'd100,       32'd0,         32'd100,       1);
    run_op("divov", F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("remov", F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);

    // start held high while busy: only the first operands count
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = F3_MUL; bus.a = 32'd3; bus.b = 32'd5;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n++;
      bus.a = 32'd1000 + i; bus.b = 32'd77 + i;
    end
    bus.start = 1'b0;
    while (!bus.done && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("hold_lat", n, 33);
    check("hold", bus.result, 32'd15);

    // start in the done cycle: result holds 15 until the new op finishes
    bus.start = 1'b1; bus.funct3 = F3_DIVU; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 64) begin
      if (n == 16) check("b2b_hold", bus.result, 32'd15);
      @(negedge clk);
      n++;
    end
    check("b2b_lat", n, 33);
    check("b2b", bus.result, 32'd14);

    // reset in the middle of a multiply
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = F3_MUL; bus.a = 32'd9; bus.b = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy",   bus.busy,   1'b0);
    check("mid_rst_done",   bus.done,   1'b0);
    check("mid_rst_result", bus.result, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("mid_rst_no_done", seen, 1'b0);

    // 16-bit instance
    run16("mulhu16", F3_MULHU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 17);
    run16("div16",   F3_DIV,   16'hFFF9, 16'd2,    16'hFFFD, 17);
    run16("divu0_16", F3_DIVU, 16'd100,  16'd0,    16'hFFFF, 1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
